// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: timestamps per-channel commit events and queues them in a show-ahead FIFO
// drained over a valid/ready port, with drop accounting for a full FIFO.
module commit_trace_buffer #(
  parameter int XLEN      = 32,
  parameter int NUM_CH    = 2,
  parameter int DEPTH     = 16,
  parameter int CYCLE_W   = 32,
  parameter int OVERWRITE = 0,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       trace_en,
  input  logic [NUM_CH-1:0]          ev_valid,
  input  logic [NUM_CH*XLEN-1:0]     ev_tag,
  input  logic [NUM_CH*32-1:0]       ev_instr,
  input  logic [NUM_CH*XLEN-1:0]     ev_addr,
  input  logic [NUM_CH*XLEN-1:0]     ev_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CYCLE_W-1:0]         out_cycle,
  output logic [CH_W-1:0]            out_ch,
  output logic [XLEN-1:0]            out_tag,
  output logic [31:0]                out_instr,
  output logic [XLEN-1:0]            out_addr,
  output logic [XLEN-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CYCLE_W-1:0]         cycle_count,
  output logic [15:0]                drop_count,
  output logic                       overflow,
  input  logic                       clr_overflow
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = LW + 2;

  logic [CYCLE_W-1:0] mem_cycle [DEPTH];
  logic [CH_W-1:0]    mem_ch    [DEPTH];
  logic [XLEN-1:0]    mem_tag   [DEPTH];
  logic [31:0]        mem_instr [DEPTH];
  logic [XLEN-1:0]    mem_addr  [DEPTH];
  logic [XLEN-1:0]    mem_data  [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW-1:0] slot [NUM_CH];
  logic          pop, do_push;
  logic [CW-1:0] k, free, pushed, discard, dropped, level_next;

  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p);
    return p & PW'(DEPTH - 1);
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [CW-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Admission: slot assignment in ascending channel order, free space and loss accounting
  always_comb begin
    pop        = out_valid & out_ready;
    k          = '0;
    do_push    = 1'b0;
    discard    = '0;
    dropped    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      slot[c] = wrap(wr_ptr + PW'(k));
      if (trace_en && ev_valid[c]) k = k + CW'(1);
    end
    free = CW'(DEPTH) - CW'(level) + CW'(pop);
    if (OVERWRITE != 0) begin
      do_push = (k != '0);
      discard = (k > free) ? (k - free) : '0;
      dropped = discard;
    end else begin
      do_push = (k != '0) && (k <= free);
      dropped = do_push ? '0 : k;
    end
    pushed     = do_push ? k : '0;
    level_next = CW'(level) + pushed - CW'(pop) - discard;
  end

  // Control state: pointers, occupancy, counter and loss flags
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      level       <= '0;
      cycle_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (trace_en) cycle_count <= cycle_count + 1'b1;
      wr_ptr <= wrap(wr_ptr + PW'(pushed));
      rd_ptr <= wrap(rd_ptr + PW'(CW'(pop) + discard));
      level  <= LW'(level_next);
      // A same-cycle drop wins over the clear but starts counting from zero
      if (dropped != '0) begin
        drop_count <= sat_add(clr_overflow ? 16'h0 : drop_count, dropped);
        overflow   <= 1'b1;
      end else if (clr_overflow) begin
        drop_count <= '0;
        overflow   <= 1'b0;
      end
    end
  end

  // Entry storage, stamped with the pre-increment cycle count
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (do_push && ev_valid[c]) begin
        mem_cycle[slot[c]] <= cycle_count;
        mem_ch[slot[c]]    <= CH_W'(c);
        mem_tag[slot[c]]   <= ev_tag[c*XLEN +: XLEN];
        mem_instr[slot[c]] <= ev_instr[c*32 +: 32];
        mem_addr[slot[c]]  <= ev_addr[c*XLEN +: XLEN];
        mem_data[slot[c]]  <= ev_data[c*XLEN +: XLEN];
      end
    end
  end

  // Show-ahead head; fields forced to zero while empty
  always_comb begin
    out_valid = (level != '0);
    out_cycle = out_valid ? mem_cycle[rd_ptr] : '0;
    out_ch    = out_valid ? mem_ch[rd_ptr]    : '0;
    out_tag   = out_valid ? mem_tag[rd_ptr]   : '0;
    out_instr = out_valid ? mem_instr[rd_ptr] : '0;
    out_addr  = out_valid ? mem_addr[rd_ptr]  : '0;
    out_data  = out_valid ? mem_data[rd_ptr]  : '0;
  end

endmodule
